// File: rtl/spi_tsense_reader_pkg.sv
// Shared state encoding and width helper for the SPI temperature-sensor reader.
package spi_tsense_reader_pkg;

    // IDLE: waiting | SETUP: CS low before SCK | SHIFT: clocking bits | HOLD: CS low after SCK | GAP: scan spacing
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    // Bits needed to index n distinct values, never less than one.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_tsense_reader_sck_gen.sv
// SCK generator: half-period down-counter producing rise/fall enables and a registered mode-0 SCK.
module spi_tsense_reader_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic stop,
    output logic sck,
    output logic sck_rise,
    output logic sck_fall,
    output logic period_end
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] half_cnt;
    logic          tick;

    assign tick       = (half_cnt == '0);
    // End of a low half; a new period starts here unless the frame has run out of bits.
    assign period_end = en & tick & ~sck;
    assign sck_rise   = period_end & ~stop;
    assign sck_fall   = en & tick & sck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_cnt <= '0;
            sck      <= 1'b0;
        end else if (!en) begin
            half_cnt <= '0;
            sck      <= 1'b0;
        end else if (tick) begin
            half_cnt <= CW'(CLK_DIV - 1);
            if (sck_rise)
                sck <= 1'b1;
            else if (sck_fall)
                sck <= 1'b0;
        end else begin
            half_cnt <= half_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/spi_tsense_reader.sv
// SPI master front end reading DATA_W-bit frames from NUM_CH serial temperature sensors,
// single-shot or continuous round-robin, fully synchronous to sysclk.
module spi_tsense_reader
    import spi_tsense_reader_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_CH   = 2,
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int IDLE_GAP = 8
) (
    input  logic                      sysclk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      cont,
    input  logic [clog2w(NUM_CH)-1:0] ch_sel,
    input  logic                      sio,
    output logic [NUM_CH-1:0]         cs_n,
    output logic                      sck,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_W-1:0]         data,
    output logic [clog2w(NUM_CH)-1:0] data_ch,
    output logic                      err
);
    localparam int CHW  = clog2w(NUM_CH);
    localparam int BW   = clog2w(DATA_W + 1);
    localparam int TMAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > IDLE_GAP) ? CS_SETUP : IDLE_GAP)
                                               : ((CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP);
    localparam int TW   = clog2w(TMAX);

    state_t            state;
    logic [TW-1:0]     tmr;
    logic [BW-1:0]     bits_left;
    logic [DATA_W-1:0] shreg;
    logic [CHW-1:0]    ch;
    logic [CHW-1:0]    ptr;
    logic [CHW-1:0]    ptr_nxt;
    logic [CHW-1:0]    launch_ch;
    logic              launch;
    logic              ch_ok;
    logic              sck_en;
    logic              sck_rise;
    logic              sck_fall;
    logic              period_end;

    assign busy    = (state != ST_IDLE);
    assign ch_ok   = (32'(ch_sel) < NUM_CH);
    assign ptr_nxt = (ptr == CHW'(NUM_CH - 1)) ? '0 : ptr + CHW'(1);
    // The generator is armed during the last SETUP cycle so the first rise lands on the SHIFT entry edge.
    assign sck_en  = ((state == ST_SETUP) && (tmr == '0)) || (state == ST_SHIFT);

    spi_tsense_reader_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk       (sysclk),
        .rst       (rst),
        .en        (sck_en),
        .stop      (bits_left == '0),
        .sck       (sck),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .period_end(period_end)
    );

    always_comb begin
        launch    = 1'b0;
        launch_ch = ptr;
        case (state)
            ST_IDLE: begin
                launch    = cont | (start & ch_ok);
                launch_ch = cont ? ptr : ch_sel;
            end
            ST_GAP: begin
                launch    = cont & (tmr == '0);
                launch_ch = ptr_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            tmr       <= '0;
            bits_left <= '0;
            shreg     <= '0;
            ch        <= '0;
            ptr       <= '0;
            cs_n      <= '1;
            done      <= 1'b0;
            err       <= 1'b0;
            data      <= '0;
            data_ch   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (sck_rise)
                shreg <= {shreg[DATA_W-2:0], sio};
            if (sck_fall)
                bits_left <= bits_left - BW'(1);
            if (launch) begin
                state     <= ST_SETUP;
                ch        <= launch_ch;
                tmr       <= TW'(CS_SETUP - 1);
                bits_left <= BW'(DATA_W);
                cs_n      <= ~(NUM_CH'(1) << launch_ch);
            end
            case (state)
                ST_IDLE: begin
                    if (start && !cont && !ch_ok)
                        err <= 1'b1;
                end
                ST_SETUP: begin
                    if (tmr == '0)
                        state <= ST_SHIFT;
                    else
                        tmr <= tmr - TW'(1);
                end
                ST_SHIFT: begin
                    if (period_end && (bits_left == '0)) begin
                        state <= ST_HOLD;
                        tmr   <= TW'(CS_HOLD - 1);
                    end
                end
                ST_HOLD: begin
                    if (tmr == '0) begin
                        cs_n    <= '1;
                        data    <= shreg;
                        data_ch <= ch;
                        done    <= 1'b1;
                        if (cont) begin
                            state <= ST_GAP;
                            tmr   <= TW'(IDLE_GAP - 1);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                ST_GAP: begin
                    if (!cont)
                        state <= ST_IDLE;
                    else if (tmr == '0)
                        ptr <= ptr_nxt;
                    else
                        tmr <= tmr - TW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tsense_reader.sv
// Bench for spi_tsense_reader: frame-window reference model checked every cycle plus directed literal checks.
module tb_spi_tsense_reader;
    localparam int DW  = 16;
    localparam int NCH = 2;
    localparam int CD  = 2;
    localparam int SU  = 2;
    localparam int HO  = 2;
    localparam int GP  = 8;
    localparam int LAT = SU + 2 * CD * DW + HO;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [0:0]  ch_sel = 1'b0;
    logic        sio;
    logic [1:0]  cs_n;
    logic        sck, busy, done, err;
    logic [15:0] data;
    logic [0:0]  data_ch;

    logic        start3 = 1'b0;
    logic [1:0]  ch_sel3 = 2'd0;
    logic [2:0]  cs_n3;
    logic        sck3, busy3, done3, err3;
    logic [7:0]  data3;
    logic [1:0]  data_ch3;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rises = 0;
    bit chk_en = 1'b0;

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc = cyc + 1;
    always @(posedge sck) rises = rises + 1;

    spi_tsense_reader dut (
        .sysclk(sysclk), .rst(rst), .start(start), .cont(cont), .ch_sel(ch_sel), .sio(sio),
        .cs_n(cs_n), .sck(sck), .busy(busy), .done(done), .data(data), .data_ch(data_ch), .err(err)
    );

    spi_tsense_reader #(.DATA_W(8), .NUM_CH(3), .CLK_DIV(1)) dut3 (
        .sysclk(sysclk), .rst(rst), .start(start3), .cont(1'b0), .ch_sel(ch_sel3), .sio(1'b1),
        .cs_n(cs_n3), .sck(sck3), .busy(busy3), .done(done3), .data(data3), .data_ch(data_ch3), .err(err3)
    );

    // Sensor model: MSB valid at CS fall, next bit after each SCK fall.
    logic [15:0] words [2];
    int          s_idx = 0;
    logic        all_hi;
    assign all_hi = &cs_n;
    always @(negedge sck or posedge all_hi) begin
        if (all_hi) s_idx = 0;
        else        s_idx = s_idx + 1;
    end
    assign sio = (all_hi || s_idx >= DW) ? 1'b0
               : (!cs_n[0] ? words[0][DW-1-s_idx] : words[1][DW-1-s_idx]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: idle / frame window / gap window, stepped once per clock edge.
    localparam int M_IDLE = 0, M_FRAME = 1, M_GAP = 2;
    int          m_mode = M_IDLE;
    int          m_cnt = 0;
    int          m_ptr = 0;
    int          m_fch = 0;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;
    logic [15:0] m_data = 16'h0;
    int          m_dch = 0;

    always @(posedge sysclk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_cnt = 0; m_ptr = 0; m_fch = 0;
            m_done = 1'b0; m_err = 1'b0; m_data = 16'h0; m_dch = 0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (cont) begin
                        m_fch = m_ptr; m_mode = M_FRAME; m_cnt = 0;
                    end else if (start) begin
                        if (int'(ch_sel) < NCH) begin
                            m_fch = int'(ch_sel); m_mode = M_FRAME; m_cnt = 0;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                end
                M_FRAME: begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == LAT) begin
                        m_done = 1'b1;
                        m_data = words[m_fch];
                        m_dch  = m_fch;
                        m_mode = cont ? M_GAP : M_IDLE;
                        m_cnt  = 0;
                    end
                end
                default: begin
                    if (!cont) begin
                        m_mode = M_IDLE;
                    end else begin
                        m_cnt = m_cnt + 1;
                        if (m_cnt == GP) begin
                            m_ptr  = (m_ptr + 1) % NCH;
                            m_fch  = m_ptr;
                            m_mode = M_FRAME;
                            m_cnt  = 0;
                        end
                    end
                end
            endcase
        end
    end

    always @(negedge sysclk) begin
        logic [1:0] e_cs;
        bit         e_sck;
        int         k;
        if (!rst && chk_en) begin
            e_cs = 2'b11;
            if (m_mode == M_FRAME) e_cs[m_fch] = 1'b0;
            k = m_cnt - SU;
            e_sck = (m_mode == M_FRAME) && (k >= 0) && (k < 2 * CD * DW) && ((k % (2 * CD)) < CD);
            check("cyc_cs_n", 32'(cs_n), 32'(e_cs));
            check("cyc_sck", 32'(sck), 32'(e_sck));
            check("cyc_busy", 32'(busy), 32'(m_mode != M_IDLE));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_err", 32'(err), 32'(m_err));
            check("cyc_data", 32'(data), 32'(m_data));
            check("cyc_data_ch", 32'(data_ch), 32'(m_dch));
            check("cyc_cs_onehot", 32'($countones(~cs_n) <= 1), 32'd1);
        end
    end

    task automatic wait_done(input int budget, input string name);
        int i;
        for (i = 0; i < budget && !done; i++) @(negedge sysclk);
        if (!done) check(name, 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_s, t_d, gap, extra, lowc;
        logic [1:0]  cs_mid;
        logic [2:0]  cs3_mid;
        int          d_ch [3];
        logic [15:0] d_dat [3];

        words[0] = 16'h1234;
        words[1] = 16'hA5C3;
        rst = 1'b1;
        repeat (3) @(negedge sysclk);
        check("rst_cs_n", 32'(cs_n), 32'h3);
        check("rst_sck", 32'(sck), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_data", 32'(data), 32'h0);
        check("rst_data_ch", 32'(data_ch), 32'h0);
        check("rst_cs_n3", 32'(cs_n3), 32'h7);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset in the middle of the shift phase
        @(negedge sysclk);
        start = 1'b1; ch_sel = 1'b0;
        @(negedge sysclk);
        start = 1'b0; rises = 0;
        for (int i = 0; i < 200 && rises < 5; i++) @(negedge sysclk);
        check("t1_reached_bit5", 32'(rises >= 5), 32'd1);
        check("t1_sck_high_before", 32'(sck), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t1_cs_n_async", 32'(cs_n), 32'h3);
        check("t1_sck_async", 32'(sck), 32'h0);
        check("t1_busy_async", 32'(busy), 32'h0);
        check("t1_data_kept", 32'(data), 32'h0);
        @(negedge sysclk);
        rst = 1'b0;

        // Single-shot on channel 1
        repeat (2) @(negedge sysclk);
        words[1] = 16'hA5C3;
        start = 1'b1; ch_sel = 1'b1; rises = 0;
        @(negedge sysclk);
        start = 1'b0; ch_sel = 1'b0; t_s = cyc;
        repeat (10) @(negedge sysclk);
        cs_mid = cs_n;
        wait_done(200, "t2_done_timeout");
        t_d = cyc;
        check("t2_latency", 32'(t_d - t_s), 32'd68);
        check("t2_data", 32'(data), 32'hA5C3);
        check("t2_data_ch", 32'(data_ch), 32'd1);
        check("t2_sck_rises", 32'(rises), 32'd16);
        check("t2_cs_n", 32'(cs_mid), 32'b01);

        // Continuous scan
        repeat (3) @(negedge sysclk);
        words[0] = 16'h1234; words[1] = 16'h8001;
        cont = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge sysclk);
            wait_done(300, "t3_done_timeout");
            d_ch[j]  = int'(data_ch);
            d_dat[j] = data;
            if (j == 0) begin
                gap = 0;
                while ((&cs_n) && gap < 50) begin
                    gap = gap + 1;
                    @(negedge sysclk);
                end
                check("t3_gap_cycles", 32'(gap), 32'd8);
            end
            if (j == 2) cont = 1'b0;
        end
        check("t3_ch0", 32'(d_ch[0]), 32'd0);
        check("t3_ch1", 32'(d_ch[1]), 32'd1);
        check("t3_ch2", 32'(d_ch[2]), 32'd0);
        check("t3_data0", 32'(d_dat[0]), 32'h1234);
        check("t3_data1", 32'(d_dat[1]), 32'h8001);
        check("t3_data2", 32'(d_dat[2]), 32'h1234);
        repeat (30) @(negedge sysclk);
        check("t3_idle_busy", 32'(busy), 32'd0);

        // START while busy, CH_SEL changed mid-frame
        start = 1'b1; ch_sel = 1'b0;
        @(negedge sysclk);
        start = 1'b0;
        repeat (10) @(negedge sysclk);
        start = 1'b1; ch_sel = 1'b1;
        repeat (20) @(negedge sysclk);
        start = 1'b0;
        wait_done(200, "t4_done_timeout");
        check("t4_data_ch", 32'(data_ch), 32'd0);
        check("t4_data", 32'(data), 32'h1234);
        extra = 0;
        repeat (100) begin
            @(negedge sysclk);
            if (done || busy) extra = extra + 1;
        end
        check("t4_no_extra_frame", 32'(extra), 32'd0);

        // START and CONT together (scan wins), then CONT dropped mid-shift
        start = 1'b1; ch_sel = 1'b1; cont = 1'b1;
        @(negedge sysclk);
        start = 1'b0; rises = 0;
        for (int i = 0; i < 200 && rises < 3; i++) @(negedge sysclk);
        cont = 1'b0;
        wait_done(200, "t6_done_timeout");
        check("t6_data_ch", 32'(data_ch), 32'd0);
        check("t6_data", 32'(data), 32'h1234);
        lowc = 0;
        repeat (40) begin
            @(negedge sysclk);
            if (!(&cs_n)) lowc = lowc + 1;
        end
        check("t6_no_cs_activity", 32'(lowc), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);

        // Three-channel instance: out-of-range select, then a frame on channel 2
        start3 = 1'b1; ch_sel3 = 2'd3;
        @(negedge sysclk);
        start3 = 1'b0;
        check("t5_err_pulse", 32'(err3), 32'd1);
        check("t5_cs_n3", 32'(cs_n3), 32'h7);
        check("t5_busy3", 32'(busy3), 32'd0);
        @(negedge sysclk);
        check("t5_err_one_cycle", 32'(err3), 32'd0);
        check("t5_busy3_after", 32'(busy3), 32'd0);
        start3 = 1'b1; ch_sel3 = 2'd2;
        @(negedge sysclk);
        start3 = 1'b0; t_s = cyc;
        repeat (3) @(negedge sysclk);
        cs3_mid = cs_n3;
        for (int i = 0; i < 100 && !done3; i++) @(negedge sysclk);
        check("t5_done3_seen", 32'(done3), 32'd1);
        check("t5_latency3", 32'(cyc - t_s), 32'd20);
        check("t5_data3", 32'(data3), 32'hFF);
        check("t5_data_ch3", 32'(data_ch3), 32'd2);
        check("t5_cs_n3_frame", 32'(cs3_mid), 32'b011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
